// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core
// load/store path (port 0) and the debug/DMA loader (port 1).
module data_mem_arbiter #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [2:0]       m0_mode,
    input  logic [WIDTH-1:0] m0_addr,
    input  logic [WIDTH-1:0] m0_wdata,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [WIDTH-1:0] m0_rdata,
    output logic             m0_err,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [2:0]       m1_mode,
    input  logic [WIDTH-1:0] m1_addr,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [WIDTH-1:0] m1_rdata,
    output logic             m1_err,
    output logic             mem_we,
    output logic [2:0]       mem_mode,
    output logic [1:0]       mem_rsrc,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    // state | meaning
    // IDLE  | no access on the memory; winner of pending requests is latched
    // ACC   | latched command drives the memory for exactly one cycle
    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             rr_last_q;
    logic             port_q;
    logic             we_q;
    logic [2:0]       mode_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [1:0]       rvalid_q;
    logic [1:0]       err_q;
    logic [WIDTH-1:0] rdata0_q;
    logic [WIDTH-1:0] rdata1_q;

    logic any_req;
    logic winner;
    logic mode_ok;
    logic addr_ok;
    logic legal;

    assign any_req = m0_req | m1_req;

    // With both requesting, the port that did not win last time goes first.
    always_comb begin
        winner = 1'b0;
        if (m0_req && m1_req) begin
            winner = ~rr_last_q;
        end else if (m1_req) begin
            winner = 1'b1;
        end
    end

    always_comb begin
        mode_ok = 1'b0;
        case (mode_q)
            3'b001, 3'b010, 3'b011, 3'b100, 3'b101: mode_ok = 1'b1;
            default:                                mode_ok = 1'b0;
        endcase
    end

    assign addr_ok = (addr_q[WIDTH-1:ADDR_W] == '0);
    assign legal   = mode_ok & addr_ok;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_ACC;
            S_ACC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        m0_gnt   = 1'b0;
        m1_gnt   = 1'b0;
        mem_we   = 1'b0;
        mem_mode = 3'b000;
        mem_rsrc = 2'b00;
        mem_addr = '0;
        mem_wd   = '0;
        if (state_q == S_ACC) begin
            m0_gnt   = ~port_q;
            m1_gnt   = port_q;
            mem_mode = mode_q;
            mem_addr = addr_q;
            mem_wd   = wdata_q;
            if (legal) begin
                mem_we   = we_q;
                mem_rsrc = we_q ? 2'b00 : 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rr_last_q <= 1'b1;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            mode_q    <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= '0;
            rvalid_q  <= 2'b00;
            err_q     <= 2'b00;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
            if (state_q == S_IDLE && any_req) begin
                rr_last_q <= winner;
                port_q    <= winner;
                we_q      <= winner ? m1_we    : m0_we;
                mode_q    <= winner ? m1_mode  : m0_mode;
                addr_q    <= winner ? m1_addr  : m0_addr;
                wdata_q   <= winner ? m1_wdata : m0_wdata;
            end
            if (state_q == S_ACC) begin
                if (!legal) begin
                    err_q[port_q] <= 1'b1;
                end else if (!we_q) begin
                    rvalid_q[port_q] <= 1'b1;
                    if (port_q) rdata1_q <= mem_rd;
                    else        rdata0_q <= mem_rd;
                end
            end
        end
    end

    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule
